cart_loader: RTL

// Routes the HPS ioctl download stream into the shared cartridge/work RAM port, and arbitrates that port with the CPU.

---
 rtl/cart_loader_pkg.sv | 16 +
 rtl/cart_loader_reset_stretcher.sv | 35 +++
 rtl/cart_loader.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/cart_loader_pkg.sv
// Shared definitions for the cartridge loader: FSM state encoding and the
// ioctl byte-address width used by the HPS download interface.
package cart_loader_pkg;

   // Width of the HPS ioctl byte address bus.
   localparam int unsigned IOCTL_ADDR_W = 25;

   // Loader sequencing states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_MASK = 2'd2,
      ST_HOLD = 2'd3
   } loader_state_t;

endpackage

// File: rtl/cart_loader_reset_stretcher.sv
// Loadable down-counter used to stretch a reset pulse for HOLD cycles.
// Ports:
//   clk    in  clock, rising edge
//   reset  in  synchronous active-high reset, clears the counter
//   load   in  reload counter with HOLD (has priority over dec)
//   dec    in  decrement counter while non-zero
//   done_c out counter is at its final cycle (count == 1)
module cart_loader_reset_stretcher #(
   parameter int unsigned HOLD = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic dec,
   output logic done_c
);

   localparam int unsigned CNT_W = $clog2(HOLD + 1);

   logic [CNT_W-1:0] count;

   // Down-counter; load wins so a restart always sees a full hold period.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= CNT_W'(HOLD);
      end else if (dec && (count != '0)) begin
         count <= count - CNT_W'(1);
      end
   end

   assign done_c = (count == CNT_W'(1));

endmodule

// File: rtl/cart_loader.sv
// Routes the HPS ioctl download stream onto the shared cartridge/work RAM
// port, arbitrates that port with the CPU, tracks the loaded image size and
// its power-of-two mirror mask, and sequences the post-download core reset.
// Ports:
//   clk_sys, reset                  clock / synchronous active-high reset
//   ioctl_download/index/wr/addr/dout  HPS download stream
//   cpu_a, cpu_we_n, cpu_d          CPU RAM access
//   ram_a, ram_we, ram_d            RAM port A (combinational, zero latency)
//   cart_size, cart_mask            accepted image size and mirror mask
//   cart_loaded, overflow           image valid / bytes dropped past MAX_SIZE
//   core_reset                      reset to the console core
module cart_loader
   import cart_loader_pkg::*;
#(
   parameter int unsigned       ADDR_W     = 16,
   parameter int unsigned       DATA_W     = 8,
   parameter logic [7:0]        CART_INDEX = 8'd1,
   parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
   parameter int unsigned       MAX_SIZE   = 2**ADDR_W,
   parameter int unsigned       RESET_HOLD = 255
) (
   input  logic                    clk_sys,
   input  logic                    reset,
   input  logic                    ioctl_download,
   input  logic [7:0]              ioctl_index,
   input  logic                    ioctl_wr,
   input  logic [IOCTL_ADDR_W-1:0] ioctl_addr,
   input  logic [7:0]              ioctl_dout,
   input  logic [ADDR_W-1:0]       cpu_a,
   input  logic                    cpu_we_n,
   input  logic [DATA_W-1:0]       cpu_d,
   output logic [ADDR_W-1:0]       ram_a,
   output logic                    ram_we,
   output logic [DATA_W-1:0]       ram_d,
   output logic [IOCTL_ADDR_W-1:0] cart_size,
   output logic [ADDR_W-1:0]       cart_mask,
   output logic                    cart_loaded,
   output logic                    overflow,
   output logic                    core_reset
);

   localparam int unsigned MCNT_W = $clog2(ADDR_W + 1);

   loader_state_t           state;
   logic [MCNT_W-1:0]       mask_cnt;
   logic                    cart_pending;
   logic                    download_q;

   logic                    is_cart;
   logic                    dl_cart;
   logic                    dl_other;
   logic                    in_range;
   logic                    byte_wr;
   logic                    start_load;
   logic                    mask_last;
   logic                    hold_load;
   logic                    hold_dec;
   logic                    hold_done;
   logic [IOCTL_ADDR_W-1:0] addr_next;
   logic [IOCTL_ADDR_W-1:0] mask_wide;
   logic [IOCTL_ADDR_W-1:0] size_m1;

   // Download classification and address checks.
   assign is_cart    = (ioctl_index == CART_INDEX);
   assign dl_cart    = ioctl_download & is_cart;
   assign dl_other   = ioctl_download & ~is_cart;
   assign in_range   = (32'(ioctl_addr) < MAX_SIZE);
   assign byte_wr    = (state == ST_LOAD) & ioctl_download & ioctl_wr & ~reset;
   assign start_load = dl_cart & (state != ST_LOAD);
   assign mask_last  = (mask_cnt == MCNT_W'(1));
   assign addr_next  = ioctl_addr + IOCTL_ADDR_W'(1);
   assign mask_wide  = IOCTL_ADDR_W'(cart_mask);
   assign size_m1    = cart_size - IOCTL_ADDR_W'(1);

   assign core_reset = reset | (state != ST_IDLE);

   // RAM port mux: downloader owns the port in LOAD, CPU otherwise.
   always_comb begin
      ram_a  = cpu_a;
      ram_d  = cpu_d;
      ram_we = ~cpu_we_n & ~core_reset;
      if (state == ST_LOAD) begin
         ram_a  = BASE_ADDR + ioctl_addr[ADDR_W-1:0];
         ram_d  = DATA_W'(ioctl_dout);
         ram_we = byte_wr & in_range;
      end
   end

   // Hold counter control. The registered download level keeps the counter
   // full for the cycle in which the download drop is first seen, so the
   // hold always spans RESET_HOLD cycles after the download ends.
   always_comb begin
      hold_load = 1'b0;
      hold_dec  = 1'b0;
      unique case (state)
         ST_IDLE: hold_load = dl_other;
         ST_LOAD: hold_load = 1'b0;
         ST_MASK: hold_load = ioctl_download | mask_last;
         ST_HOLD: begin
            hold_load = ioctl_download | download_q;
            hold_dec  = ~(ioctl_download | download_q);
         end
         default: hold_load = 1'b0;
      endcase
   end

   cart_loader_reset_stretcher #(
      .HOLD (RESET_HOLD)
   ) u_hold (
      .clk    (clk_sys),
      .reset  (reset),
      .load   (hold_load),
      .dec    (hold_dec),
      .done_c (hold_done)
   );

   // Loader FSM with image bookkeeping.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state        <= ST_IDLE;
         cart_size    <= '0;
         cart_mask    <= '1;
         cart_loaded  <= 1'b0;
         overflow     <= 1'b0;
         mask_cnt     <= '0;
         cart_pending <= 1'b0;
         download_q   <= 1'b0;
      end else begin
         download_q <= ioctl_download;

         // Mask search: grow the mask one bit per cycle until it covers
         // cart_size-1. Runs off its own counter so a HOLD restart from an
         // unrelated download cannot leave it half built.
         if (mask_cnt != '0) begin
            mask_cnt <= mask_cnt - MCNT_W'(1);
            if ((cart_size != '0) && (mask_wide < size_m1)) begin
               cart_mask <= {cart_mask[ADDR_W-2:0], 1'b1};
            end
         end

         if (start_load) begin
            state        <= ST_LOAD;
            cart_loaded  <= 1'b0;
            overflow     <= 1'b0;
            cart_size    <= '0;
            mask_cnt     <= '0;
            cart_pending <= 1'b0;
         end else begin
            unique case (state)
               ST_IDLE: begin
                  if (dl_other) begin
                     state <= ST_HOLD;
                  end
               end
               ST_LOAD: begin
                  if (!ioctl_download) begin
                     state        <= ST_MASK;
                     mask_cnt     <= MCNT_W'(ADDR_W);
                     cart_mask    <= (cart_size == '0) ? '1 : '0;
                     cart_pending <= 1'b1;
                  end else if (ioctl_wr) begin
                     if (in_range) begin
                        if (addr_next > cart_size) begin
                           cart_size <= addr_next;
                        end
                     end else begin
                        overflow <= 1'b1;
                     end
                  end
               end
               ST_MASK: begin
                  if (dl_other || mask_last) begin
                     state <= ST_HOLD;
                  end
               end
               ST_HOLD: begin
                  if (!ioctl_download && !download_q && hold_done) begin
                     state        <= ST_IDLE;
                     cart_pending <= 1'b0;
                     if (cart_pending && (cart_size != '0)) begin
                        cart_loaded <= 1'b1;
                     end
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule
